// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// valid/ready memory port, a memory-wait timeout and sticky trap flags.
module multicycle_ctrl #(
  parameter int TIMEOUT   = 16,
  parameter bit EN_BRANCH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_sel,
  output logic [2:0] imm_sel,
  output logic       src_a_sel,
  output logic       src_b_sel,
  output logic       alu_set,
  output logic [2:0] alu_op,
  output logic       shamt_sel,
  output logic       reg_write,
  output logic [2:0] regd_sel,
  output logic       recode,
  output logic       illegal,
  output logic       bus_err
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_U = 3'b010,
                         IMM_J = 3'b100, IMM_B = 3'b101;
  localparam logic [2:0] RD_MEM = 3'b000, RD_ALU = 3'b001, RD_SFT = 3'b010,
                         RD_IMM = 3'b011, RD_PC4 = 3'b100;

  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TMAX_V = TW'(TMAX);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef struct packed {
    logic [2:0] imm_sel;
    logic       src_a_sel;
    logic       src_b_sel;
    logic       alu_set;
    logic       shamt_sel;
    logic [2:0] regd_sel;
  } dec_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  dec_t          dec;
  logic          legal, is_shift, is_store, is_branch, is_jump;
  logic          mem_req_i, ir_write_i, pc_write_i, reg_write_i;
  logic          timeout_hit, illegal_set, bus_err_set;

  // Opcode decode; the IR is stable from DECODE through WB so this stays live.
  always_comb begin
    dec      = '0;
    legal    = 1'b0;
    is_shift = funct3 inside {3'b001, 3'b101};
    case (opcode)
      OPC_OP:     begin legal = 1'b1; dec.src_a_sel = 1'b1;
                        dec.regd_sel = is_shift ? RD_SFT : RD_ALU; end
      OPC_OP_IMM: begin legal = 1'b1; dec.imm_sel = IMM_I; dec.src_a_sel = 1'b1;
                        dec.src_b_sel = 1'b1; dec.shamt_sel = 1'b1;
                        dec.regd_sel = is_shift ? RD_SFT : RD_ALU; end
      OPC_LUI:    begin legal = 1'b1; dec.imm_sel = IMM_U; dec.regd_sel = RD_IMM; end
      OPC_AUIPC:  begin legal = 1'b1; dec.imm_sel = IMM_U; dec.src_b_sel = 1'b1;
                        dec.alu_set = 1'b1; dec.regd_sel = RD_ALU; end
      OPC_LOAD:   begin legal = 1'b1; dec.imm_sel = IMM_I; dec.src_a_sel = 1'b1;
                        dec.src_b_sel = 1'b1; dec.alu_set = 1'b1; dec.regd_sel = RD_MEM; end
      OPC_STORE:  begin legal = 1'b1; dec.imm_sel = IMM_S; dec.src_a_sel = 1'b1;
                        dec.src_b_sel = 1'b1; dec.alu_set = 1'b1; end
      OPC_BRANCH: begin legal = EN_BRANCH; dec.imm_sel = IMM_B; dec.src_b_sel = 1'b1;
                        dec.alu_set = 1'b1; end
      OPC_JAL:    begin legal = EN_BRANCH; dec.imm_sel = IMM_J; dec.src_b_sel = 1'b1;
                        dec.alu_set = 1'b1; dec.regd_sel = RD_PC4; end
      OPC_JALR:   begin legal = EN_BRANCH; dec.imm_sel = IMM_I; dec.src_a_sel = 1'b1;
                        dec.src_b_sel = 1'b1; dec.alu_set = 1'b1; dec.regd_sel = RD_PC4; end
      default:    ;
    endcase
  end

  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);

  assign timeout_hit = (TIMEOUT > 0) && mem_req_i && !mem_ready && (timer == TMAX_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      timer   <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_nxt;
      // Timer only advances while a request stays unanswered in the same state.
      if (state_nxt != state || !mem_req_i || mem_ready) timer <= '0;
      else                                               timer <= timer + TW'(1);
      if (illegal_set) illegal <= 1'b1;
      if (bus_err_set) bus_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    illegal_set = 1'b0;
    bus_err_set = 1'b0;
    case (state)
      S_FETCH:  if (timeout_hit) begin state_nxt = S_TRAP; bus_err_set = 1'b1; end
                else if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: if (legal) state_nxt = S_EXEC;
                else begin state_nxt = S_TRAP; illegal_set = 1'b1; end
      S_EXEC:   if (is_branch)                              state_nxt = S_FETCH;
                else if (is_store || opcode == OPC_LOAD)    state_nxt = S_MEM;
                else                                        state_nxt = S_WB;
      S_MEM:    if (timeout_hit) begin state_nxt = S_TRAP; bus_err_set = 1'b1; end
                else if (mem_ready) state_nxt = is_store ? S_FETCH : S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req_i   = 1'b0;
    ir_write_i  = 1'b0;
    pc_write_i  = 1'b0;
    reg_write_i = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    pc_sel      = 1'b0;
    imm_sel     = dec.imm_sel;
    src_a_sel   = dec.src_a_sel;
    src_b_sel   = dec.src_b_sel;
    alu_set     = dec.alu_set;
    alu_op      = 3'b000;
    shamt_sel   = dec.shamt_sel;
    regd_sel    = dec.regd_sel;
    recode      = (opcode == OPC_OP);
    case (state)
      S_FETCH: begin mem_req_i = 1'b1; ir_write_i = mem_ready; end
      S_EXEC:  if (is_branch) begin pc_write_i = 1'b1; pc_sel = branch_taken; end
      S_MEM:   begin
        mem_req_i  = 1'b1;
        addr_sel   = 1'b1;
        mem_we     = is_store;
        pc_write_i = is_store && mem_ready;
      end
      S_WB:    begin reg_write_i = 1'b1; pc_write_i = 1'b1; pc_sel = is_jump; end
      default: ;
    endcase
  end

  // Strobes are masked by reset so an in-flight request dies the instant rst_n falls.
  assign mem_req   = mem_req_i   & rst_n;
  assign ir_write  = ir_write_i  & rst_n;
  assign pc_write  = pc_write_i  & rst_n;
  assign reg_write = reg_write_i & rst_n;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expectation queue built from the
// instruction-sequencing rules, plus directed checks on a small-timeout instance.
module tb_multicycle_ctrl;
  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111,
                         AUIPC = 7'b0010111, LOAD = 7'b0000011, STORE = 7'b0100011,
                         BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, branch_taken, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic mem_req, mem_we, addr_sel, ir_write, pc_write, pc_sel, src_a_sel, src_b_sel;
  logic alu_set, shamt_sel, reg_write, recode, illegal, bus_err;
  logic [2:0] imm_sel, alu_op, regd_sel;

  multicycle_ctrl #(.TIMEOUT(16), .EN_BRANCH(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write),
    .pc_sel(pc_sel), .imm_sel(imm_sel), .src_a_sel(src_a_sel), .src_b_sel(src_b_sel),
    .alu_set(alu_set), .alu_op(alu_op), .shamt_sel(shamt_sel), .reg_write(reg_write),
    .regd_sel(regd_sel), .recode(recode), .illegal(illegal), .bus_err(bus_err));

  logic       rst2_n, taken2, ready2;
  logic [6:0] opc2;
  logic [2:0] f3_2;
  logic req2, we2, asel2, irw2, pcw2, pcs2, srca2, srcb2, aset2, sham2, rw2, rec2, ill2, berr2;
  logic [2:0] imm2, aop2, regd2;

  multicycle_ctrl #(.TIMEOUT(4), .EN_BRANCH(1'b0)) dut2 (
    .clk(clk), .rst_n(rst2_n), .opcode(opc2), .funct3(f3_2),
    .branch_taken(taken2), .mem_ready(ready2), .mem_req(req2),
    .mem_we(we2), .addr_sel(asel2), .ir_write(irw2), .pc_write(pcw2),
    .pc_sel(pcs2), .imm_sel(imm2), .src_a_sel(srca2), .src_b_sel(srcb2),
    .alu_set(aset2), .alu_op(aop2), .shamt_sel(sham2), .reg_write(rw2),
    .regd_sel(regd2), .recode(rec2), .illegal(ill2), .bus_err(berr2));

  typedef struct packed {
    logic       ready, taken;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       req, we, asel, irw, pcw, pcs, rw;
    logic [2:0] regd;
    logic       ill, berr, xchk;
  } cyc_t;

  cyc_t exp_q[$];
  cyc_t cur;
  bit   chk_en = 1'b0;
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    else n_pass++;
  endtask

  function automatic cyc_t blank(input logic [6:0] o, input logic [2:0] f);
    cyc_t c;
    c = '0;
    c.ready = 1'b1;
    c.opc = o;
    c.f3 = f;
    return c;
  endfunction

  // Expected cycle-by-cycle trace of one instruction, from the sequencing rules.
  task automatic gen(input logic [6:0] o, input logic [2:0] f, input bit tk,
                     input int wf, input int wm, input bit complete = 1'b1);
    cyc_t c;
    bit ld = (o == LOAD), st = (o == STORE), br = (o == BR), jp = (o == JAL || o == JALR);
    bit legal = o inside {OP, OPI, LUI, AUIPC, LOAD, STORE, BR, JAL, JALR};
    for (int i = 0; i <= wf; i++) begin
      c = blank(o, f); c.ready = (i == wf); c.req = 1'b1; c.irw = (i == wf);
      exp_q.push_back(c);
    end
    exp_q.push_back(blank(o, f));
    if (!legal) begin
      for (int i = 0; i < 5; i++) begin c = blank(o, f); c.ill = 1'b1; exp_q.push_back(c); end
      return;
    end
    c = blank(o, f); c.xchk = 1'b1; c.taken = tk;
    if (br) begin c.pcw = 1'b1; c.pcs = tk; end
    exp_q.push_back(c);
    if (br) return;
    if (ld || st) begin
      for (int i = 0; i <= wm; i++) begin
        if (i == wm && !complete) return;
        c = blank(o, f); c.ready = (i == wm); c.req = 1'b1; c.asel = 1'b1; c.we = st;
        if (st && i == wm) c.pcw = 1'b1;
        exp_q.push_back(c);
      end
      if (st) return;
    end
    c = blank(o, f); c.rw = 1'b1; c.pcw = 1'b1; c.pcs = jp;
    if (ld)                                 c.regd = 3'b000;
    else if (jp)                            c.regd = 3'b100;
    else if (o == LUI)                      c.regd = 3'b011;
    else if (o != AUIPC && f[1:0] == 2'b01) c.regd = 3'b010;
    else                                    c.regd = 3'b001;
    exp_q.push_back(c);
  endtask

  task automatic run_queue();
    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      mem_ready = cur.ready; branch_taken = cur.taken; opcode = cur.opc; funct3 = cur.f3;
      chk_en = 1'b1;
      @(posedge clk); #1;
    end
    chk_en = 1'b0;
  endtask

  task automatic check_exec(input logic [6:0] o);
    chk("recode", recode, (o == OP));
    case (o)
      OP:    begin chk("srca", src_a_sel, 1); chk("srcb", src_b_sel, 0);
                   chk("alu_set", alu_set, 0); chk("shamt", shamt_sel, 0); end
      OPI:   begin chk("imm", imm_sel, 3'b000); chk("srca", src_a_sel, 1); chk("srcb", src_b_sel, 1);
                   chk("alu_set", alu_set, 0); chk("shamt", shamt_sel, 1); end
      LUI:   chk("imm", imm_sel, 3'b010);
      AUIPC: begin chk("imm", imm_sel, 3'b010); chk("srca", src_a_sel, 0); chk("srcb", src_b_sel, 1);
                   chk("alu_set", alu_set, 1); chk("alu_op", alu_op, 3'b000); end
      LOAD, JALR: begin chk("imm", imm_sel, 3'b000); chk("srca", src_a_sel, 1); chk("srcb", src_b_sel, 1);
                   chk("alu_set", alu_set, 1); chk("alu_op", alu_op, 3'b000); end
      STORE: begin chk("imm", imm_sel, 3'b001); chk("srca", src_a_sel, 1); chk("srcb", src_b_sel, 1);
                   chk("alu_set", alu_set, 1); chk("alu_op", alu_op, 3'b000); end
      JAL:   begin chk("imm", imm_sel, 3'b100); chk("srca", src_a_sel, 0); chk("srcb", src_b_sel, 1);
                   chk("alu_set", alu_set, 1); chk("alu_op", alu_op, 3'b000); end
      BR:    begin chk("imm", imm_sel, 3'b101); chk("srca", src_a_sel, 0); chk("srcb", src_b_sel, 1);
                   chk("alu_set", alu_set, 1); chk("alu_op", alu_op, 3'b000); end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_req", mem_req, cur.req);
      chk("ir_write", ir_write, cur.irw);
      chk("pc_write", pc_write, cur.pcw);
      chk("reg_write", reg_write, cur.rw);
      chk("illegal", illegal, cur.ill);
      chk("bus_err", bus_err, cur.berr);
      if (cur.req) begin chk("addr_sel", addr_sel, cur.asel); chk("mem_we", mem_we, cur.we); end
      if (cur.pcw) chk("pc_sel", pc_sel, cur.pcs);
      if (cur.rw)  chk("regd_sel", regd_sel, cur.regd);
      if (cur.xchk) check_exec(cur.opc);
    end
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; opcode = '0; funct3 = '0;
    rst2_n = 1'b0; ready2 = 1'b0; taken2 = 1'b0; opc2 = JAL; f3_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);   chk("rst_ir_write", ir_write, 0);
    chk("rst_pc_write", pc_write, 0); chk("rst_reg_write", reg_write, 0);
    chk("rst_illegal", illegal, 0);   chk("rst_bus_err", bus_err, 0);
    rst_n = 1'b1;
    #1 chk("post_rst_mem_req", mem_req, 1);
    @(posedge clk); #1;

    // addi x1,x0,5 : FETCH, DECODE, EXEC, WB
    gen(OPI, 3'b000, 0, 0, 0); chk("lat_addi", 8'(exp_q.size()), 4); run_queue();
    gen(OP, 3'b000, 0, 0, 0);  run_queue();
    gen(OP, 3'b001, 0, 0, 0);  run_queue();
    gen(OPI, 3'b001, 0, 0, 0); run_queue();
    gen(OPI, 3'b101, 0, 1, 0); run_queue();
    gen(LUI, 3'b000, 0, 0, 0); run_queue();
    gen(AUIPC, 3'b000, 0, 0, 0); run_queue();
    gen(LOAD, 3'b010, 0, 0, 0); chk("lat_lw", 8'(exp_q.size()), 5); run_queue();
    gen(LOAD, 3'b010, 0, 0, 3); chk("lat_lw_w3", 8'(exp_q.size()), 8); run_queue();
    gen(STORE, 3'b010, 0, 0, 0); chk("lat_sw", 8'(exp_q.size()), 4); run_queue();
    gen(STORE, 3'b010, 0, 2, 2); run_queue();
    gen(BR, 3'b000, 1, 0, 0); chk("lat_beq", 8'(exp_q.size()), 3); run_queue();
    gen(BR, 3'b000, 0, 0, 0); run_queue();
    gen(JAL, 3'b000, 0, 0, 0); run_queue();
    gen(JALR, 3'b000, 0, 0, 0); run_queue();
    // Longest waits that must not time out with TIMEOUT=16
    gen(OPI, 3'b000, 0, 15, 0); run_queue();
    gen(LOAD, 3'b010, 0, 0, 15); run_queue();

    // Illegal opcode: trap, memory silent until reset
    gen(7'b0000000, 3'b000, 0, 0, 0); run_queue();
    rst_n = 1'b0;
    #1 chk("ill_rst_clr", illegal, 0); chk("ill_rst_req", mem_req, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    gen(OPI, 3'b000, 0, 0, 0); run_queue();

    // Reset pulse while a store waits in MEM
    gen(STORE, 3'b010, 0, 0, 5, 1'b0); run_queue();
    mem_ready = 1'b0;
    #2 chk("mem_rst_pre_req", mem_req, 1); rst_n = 1'b0;
    #1 chk("mem_rst_req", mem_req, 0); chk("mem_rst_pcw", pc_write, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1 chk("mem_rst_fetch_req", mem_req, 1); chk("mem_rst_fetch_asel", addr_sel, 0);
    chk("mem_rst_flags", {illegal, bus_err}, 0);
    @(posedge clk); #1;
    gen(OPI, 3'b000, 0, 0, 0); run_queue();

    // TIMEOUT=4, memory never ready: four FETCH cycles then bus error
    rst2_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2 chk("to_req", req2, 1); chk("to_berr", berr2, 0);
      @(posedge clk); #1;
    end
    #2 chk("to_berr_set", berr2, 1); chk("to_req_drop", req2, 0);
    @(posedge clk); #1 chk("to_trap_hold", req2, 0);
    rst2_n = 1'b0;
    #1 chk("to_rst_berr", berr2, 0);
    @(posedge clk); #1 rst2_n = 1'b1; ready2 = 1'b1;
    // EN_BRANCH=0: jal traps as illegal
    #2 chk("jal_irw", irw2, 1);
    @(posedge clk); #3 chk("jal_dec_ill", ill2, 0); chk("jal_dec_req", req2, 0);
    @(posedge clk); #3 chk("jal_ill", ill2, 1); chk("jal_trap_req", req2, 0);
    chk("jal_no_rw", rw2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
